tdm_master_ctrl: RTL and testbench

Bus master and sequencer for the TDM microphone array front end. Generates the serial bit clock (SCK) and one-bit word-select frame pulse (WS) from the 100 MHz system clock. Runs and stops the bus on frame boundaries only. Monitors the receiver's per-frame valid pulse to count frames and flag missed frames. Sits between system control and the TDM receiver/microphones. Its `sck_out`/`ws_out` drive both the mic pins and the receiver's `sck_in`/`ws_in`.

---
 rtl/tdm_master_ctrl_if.sv | 42 ++++
 rtl/tdm_master_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tdm_master_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_master_ctrl_if.sv
// Control/status bus between system control and the TDM master sequencer.
// The master modport is the sequencer's view; slave is the system-control side.
interface tdm_master_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             enable_in;
  logic             clear_in;
  logic             audio_valid_in;
  logic             sck_out;
  logic             ws_out;
  logic             frame_start_out;
  logic             busy_out;
  logic [CNT_W-1:0] frame_count_out;
  logic [CNT_W-1:0] miss_count_out;
  logic             error_out;

  modport master (
    input  enable_in,
    input  clear_in,
    input  audio_valid_in,
    output sck_out,
    output ws_out,
    output frame_start_out,
    output busy_out,
    output frame_count_out,
    output miss_count_out,
    output error_out
  );

  modport slave (
    output enable_in,
    output clear_in,
    output audio_valid_in,
    input  sck_out,
    input  ws_out,
    input  frame_start_out,
    input  busy_out,
    input  frame_count_out,
    input  miss_count_out,
    input  error_out
  );
endinterface

// File: rtl/tdm_master_ctrl.sv
// TDM bus master: generates SCK/WS from clk_in, starts and stops on frame
// boundaries, and counts completed and missed frames from the receiver's valid pulse.
module tdm_master_ctrl #(
  parameter int SCK_DIV   = 16,
  parameter int SLOTS     = 4,
  parameter int SLOT_BITS = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  tdm_master_ctrl_if.master bus
);

  localparam int FRAME_SCK = 1 + SLOTS * SLOT_BITS;
  localparam int BIT_W     = $clog2(FRAME_SCK);
  localparam int DIV_W     = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_SCK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [BIT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             sck_r, sck_s;
  logic             ws_r, ws_s;
  logic             frame_start_r, frame_start_s;
  logic             busy_r, busy_s;
  logic             seen_valid_r, seen_valid_s;
  logic             complete_s;
  logic [CNT_W-1:0] frame_count_r, frame_count_s;
  logic [CNT_W-1:0] miss_count_r, miss_count_s;
  logic             error_r, error_s;
  logic             div_wrap_s;
  logic             frame_wrap_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  assign div_wrap_s   = (div_cnt_r == DIV_LAST);
  assign frame_wrap_s = (bit_cnt_r == BIT_LAST);

  // Sequencer next state: SCK/WS generation and frame-boundary run/stop decisions.
  always_comb begin
    state_s       = state_r;
    div_cnt_s     = div_cnt_r;
    bit_cnt_s     = bit_cnt_r;
    sck_s         = sck_r;
    ws_s          = ws_r;
    frame_start_s = 1'b0;
    busy_s        = busy_r;
    seen_valid_s  = seen_valid_r;
    complete_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        div_cnt_s    = {DIV_W{1'b0}};
        bit_cnt_s    = {BIT_W{1'b0}};
        sck_s        = 1'b0;
        seen_valid_s = 1'b0;
        if (bus.enable_in) begin
          state_s       = ST_RUN;
          ws_s          = 1'b1;
          frame_start_s = 1'b1;
          busy_s        = 1'b1;
        end else begin
          state_s = ST_IDLE;
          ws_s    = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        busy_s       = 1'b1;
        seen_valid_s = seen_valid_r | bus.audio_valid_in;
        state_s      = bus.enable_in ? ST_RUN : ST_DRAIN;
        if (div_wrap_s) begin
          div_cnt_s = {DIV_W{1'b0}};
          sck_s     = ~sck_r;
          // WS and bit_cnt only move on the falling SCK toggle, keeping WS stable at rising edges.
          if (sck_r) begin
            if (frame_wrap_s) begin
              complete_s   = 1'b1;
              bit_cnt_s    = {BIT_W{1'b0}};
              seen_valid_s = 1'b0;
              if (bus.enable_in) begin
                state_s       = ST_RUN;
                ws_s          = 1'b1;
                frame_start_s = 1'b1;
              end else begin
                state_s = ST_IDLE;
                ws_s    = 1'b0;
                busy_s  = 1'b0;
              end
            end else begin
              bit_cnt_s = bit_cnt_r + BIT_W'(1);
              ws_s      = 1'b0;
            end
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_s      = ST_IDLE;
        div_cnt_s    = {DIV_W{1'b0}};
        bit_cnt_s    = {BIT_W{1'b0}};
        sck_s        = 1'b0;
        ws_s         = 1'b0;
        busy_s       = 1'b0;
        seen_valid_s = 1'b0;
      end
    endcase
  end

  // Status counters; a clear in the completion cycle drops that completion.
  always_comb begin
    frame_count_s = frame_count_r;
    miss_count_s  = miss_count_r;
    error_s       = error_r;
    if (bus.clear_in) begin
      frame_count_s = {CNT_W{1'b0}};
      miss_count_s  = {CNT_W{1'b0}};
      error_s       = 1'b0;
    end else if (complete_s) begin
      frame_count_s = frame_count_r + CNT_W'(1);
      if (!seen_valid_r) begin
        miss_count_s = sat_inc(miss_count_r);
        error_s      = 1'b1;
      end else begin
        miss_count_s = miss_count_r;
        error_s      = error_r;
      end
    end else begin
      frame_count_s = frame_count_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r       <= ST_IDLE;
      div_cnt_r     <= {DIV_W{1'b0}};
      bit_cnt_r     <= {BIT_W{1'b0}};
      sck_r         <= 1'b0;
      ws_r          <= 1'b0;
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
      seen_valid_r  <= 1'b0;
      frame_count_r <= {CNT_W{1'b0}};
      miss_count_r  <= {CNT_W{1'b0}};
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      div_cnt_r     <= div_cnt_s;
      bit_cnt_r     <= bit_cnt_s;
      sck_r         <= sck_s;
      ws_r          <= ws_s;
      frame_start_r <= frame_start_s;
      busy_r        <= busy_s;
      seen_valid_r  <= seen_valid_s;
      frame_count_r <= frame_count_s;
      miss_count_r  <= miss_count_s;
      error_r       <= error_s;
    end
  end

  assign bus.sck_out         = sck_r;
  assign bus.ws_out          = ws_r;
  assign bus.frame_start_out = frame_start_r;
  assign bus.busy_out        = busy_r;
  assign bus.frame_count_out = frame_count_r;
  assign bus.miss_count_out  = miss_count_r;
  assign bus.error_out       = error_r;

endmodule

// File: tb/tb_tdm_master_ctrl.sv
// Bench for tdm_master_ctrl: directed steps plus random stimulus, checked against
// a frame-time model (position t within the frame, frame length L clk cycles).
module tb_tdm_master_ctrl;
  localparam int D         = 4;
  localparam int SLOTS     = 4;
  localparam int SLOT_BITS = 32;
  localparam int CNT_W     = 16;
  localparam int FRAME_SCK = 1 + SLOTS * SLOT_BITS;
  localparam int L         = FRAME_SCK * 2 * D;

  logic clk = 1'b0;
  logic rst_n;

  tdm_master_ctrl_if #(.CNT_W(CNT_W)) bus ();

  tdm_master_ctrl #(
    .SCK_DIV(D), .SLOTS(SLOTS), .SLOT_BITS(SLOT_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model
  bit m_run;
  int m_t;
  int m_frames;
  int m_miss;
  bit m_err;
  bit m_seen;
  int m_comp_total = 0;

  // stimulus control and measurements
  bit valid_en;
  int valid_pos;
  int cyc = 0;
  int fs_times[$];
  int sck_rise_prev = -1;
  int sck_period = 0;
  logic sck_prev = 1'b0;
  int ws_run = 0;
  int ws_len = 0;
  int busy_low = 0;
  int saved;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_frames = 0; m_miss = 0; m_err = 1'b0; m_seen = 1'b0;
  endtask

  task automatic model_step();
    bit complete;
    bit old_run;
    bit old_seen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    complete = 1'b0;
    old_run  = m_run;
    old_seen = m_seen;
    if (!m_run) begin
      if (bus.enable_in) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == L - 1) begin
      complete = 1'b1;
      if (bus.enable_in) m_t = 0;
      else m_run = 1'b0;
    end else begin
      m_t++;
    end
    if (bus.clear_in) begin
      m_frames = 0; m_miss = 0; m_err = 1'b0;
    end else if (complete) begin
      m_frames = (m_frames + 1) % (1 << CNT_W);
      if (!old_seen) begin
        if (m_miss < (1 << CNT_W) - 1) m_miss++;
        m_err = 1'b1;
      end
    end
    if (complete || !old_run) m_seen = 1'b0;
    else if (bus.audio_valid_in) m_seen = 1'b1;
    if (complete) m_comp_total++;
  endtask

  task automatic compare_all();
    check("sck",         bus.sck_out,         m_run && ((m_t % (2 * D)) >= D));
    check("ws",          bus.ws_out,          m_run && (m_t < 2 * D));
    check("frame_start", bus.frame_start_out, m_run && (m_t == 0));
    check("busy",        bus.busy_out,        m_run);
    check("frame_count", bus.frame_count_out, m_frames);
    check("miss_count",  bus.miss_count_out,  m_miss);
    check("error",       bus.error_out,       m_err);
  endtask

  task automatic observe();
    if (bus.frame_start_out === 1'b1) fs_times.push_back(cyc);
    if (bus.sck_out === 1'b1 && sck_prev === 1'b0) begin
      if (sck_rise_prev >= 0) sck_period = cyc - sck_rise_prev;
      sck_rise_prev = cyc;
    end
    sck_prev = bus.sck_out;
    if (bus.ws_out === 1'b1) begin
      ws_run++;
    end else begin
      if (ws_run > 0) ws_len = ws_run;
      ws_run = 0;
    end
    if (bus.busy_out !== 1'b1) busy_low++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    observe();
    compare_all();
    bus.audio_valid_in = valid_en && m_run && (m_t == valid_pos);
  endtask

  task automatic run_completions(input int n);
    int target;
    int budget;
    target = m_comp_total + n;
    budget = (n + 2) * L;
    while (m_comp_total < target && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_completion", m_comp_total, target);
  endtask

  task automatic run_to_t(input int t);
    bit hit;
    int budget;
    hit = 1'b0;
    budget = 2 * L + 8;
    while (!hit && budget > 0) begin
      tick();
      hit = m_run && (m_t == t);
      budget--;
    end
    check("wait_position", hit, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.enable_in = 1'b0;
    bus.clear_in = 1'b0;
    bus.audio_valid_in = 1'b0;
    valid_en = 1'b0;
    valid_pos = L - 2;
    model_reset();

    // reset state
    repeat (3) tick();
    check("rst_sck", bus.sck_out, 1'b0);
    check("rst_ws", bus.ws_out, 1'b0);
    check("rst_fs", bus.frame_start_out, 1'b0);
    check("rst_busy", bus.busy_out, 1'b0);
    check("rst_frames", bus.frame_count_out, 16'd0);
    check("rst_miss", bus.miss_count_out, 16'd0);
    check("rst_error", bus.error_out, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", bus.busy_out, 1'b0);

    // start, valid 2 cycles after the 129th SCK rise in every frame
    valid_en = 1'b1;
    valid_pos = (FRAME_SCK - 1) * 2 * D + D + 2;
    fs_times.delete();
    bus.enable_in = 1'b1;
    tick();
    check("start_fs", bus.frame_start_out, 1'b1);
    check("start_ws", bus.ws_out, 1'b1);
    check("start_busy", bus.busy_out, 1'b1);
    run_completions(1);
    check("ws_width", ws_len, 2 * D);
    check("sck_period", sck_period, 2 * D);
    run_completions(4);
    check("fs_spacing", (fs_times.size() >= 2) ? (fs_times[1] - fs_times[0]) : -1, L);
    check("five_frames", bus.frame_count_out, 16'd5);
    check("five_no_miss", bus.miss_count_out, 16'd0);
    check("five_no_error", bus.error_out, 1'b0);

    // clear coinciding with a completion wins
    run_to_t(L - 1);
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    check("clr_wrap_frames", bus.frame_count_out, 16'd0);
    check("clr_wrap_error", bus.error_out, 1'b0);

    // missed frame 3 of 5
    valid_pos = $urandom_range(L - 2, 1);
    run_completions(2);
    check("pre_miss_error", bus.error_out, 1'b0);
    valid_en = 1'b0;
    run_completions(1);
    check("miss_at_wrap", bus.miss_count_out, 16'd1);
    check("error_at_wrap", bus.error_out, 1'b1);
    valid_en = 1'b1;
    valid_pos = $urandom_range(L - 2, 1);
    run_completions(2);
    check("miss_frames", bus.frame_count_out, 16'd5);
    check("miss_count", bus.miss_count_out, 16'd1);
    check("error_sticky", bus.error_out, 1'b1);
    repeat ($urandom_range(500, 1)) tick();
    bus.clear_in = 1'b1;
    tick();
    bus.clear_in = 1'b0;
    check("clr_frames", bus.frame_count_out, 16'd0);
    check("clr_miss", bus.miss_count_out, 16'd0);
    check("clr_error", bus.error_out, 1'b0);

    // drain: drop enable at bit 40
    run_to_t(40 * 2 * D + $urandom_range(2 * D - 1, 0));
    bus.enable_in = 1'b0;
    saved = m_frames;
    run_completions(1);
    check("drain_busy", bus.busy_out, 1'b0);
    check("drain_sck", bus.sck_out, 1'b0);
    check("drain_frames", bus.frame_count_out, saved + 1);
    repeat (40) tick();
    check("idle_sck", bus.sck_out, 1'b0);
    check("idle_ws", bus.ws_out, 1'b0);

    // re-enable inside the drain
    bus.enable_in = 1'b1;
    tick();
    check("restart_fs", bus.frame_start_out, 1'b1);
    busy_low = 0;
    saved = m_frames;
    run_to_t(40 * 2 * D + $urandom_range(2 * D - 1, 0));
    bus.enable_in = 1'b0;
    run_to_t(90 * 2 * D + $urandom_range(2 * D - 1, 0));
    bus.enable_in = 1'b1;
    run_completions(2);
    check("reenable_busy_gap", busy_low, 0);
    check("reenable_frames", bus.frame_count_out, saved + 2);

    // asynchronous reset mid-frame, between clock edges
    run_to_t($urandom_range(L - 100, 100));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sck", bus.sck_out, 1'b0);
    check("arst_ws", bus.ws_out, 1'b0);
    check("arst_busy", bus.busy_out, 1'b0);
    check("arst_frames", bus.frame_count_out, 16'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ws", bus.ws_out, 1'b1);
    check("post_rst_fs", bus.frame_start_out, 1'b1);
    run_completions(1);
    check("post_rst_frames", bus.frame_count_out, 16'd1);

    // random enable/clear/valid traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (m_run && m_t == 0) begin
        valid_en = ($urandom_range(3, 0) != 0);
        valid_pos = $urandom_range(L - 2, 1);
      end
      if ($urandom_range(299, 0) == 0) bus.enable_in = ~bus.enable_in;
      bus.clear_in = ($urandom_range(499, 0) == 0);
      if ($urandom_range(199, 0) == 0) bus.audio_valid_in = 1'b1;
    end
    bus.clear_in = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
